count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Command-driven controller for the 16-bit up/down event counter (inc/uphdl interface).
//  Accepts "move N steps up/down" commands over a valid/ready handshake.
//  Issues exactly one inc pulse per step, with uphdl held at the commanded direction.
//  Reads the counter's registered count back and stops at programmable limits, so the
//  counter never wraps. Sits between the user command logic and the counter instance.
// PARAMETERS
//  WIDTH       16       width of count_in and cmd_steps
//  UP_LIMIT    16'hFFFF highest count allowed; no up-pulse is issued when count_in==UP_LIMIT
//  DOWN_LIMIT  16'h0000 lowest count allowed; no down-pulse is issued when count_in==DOWN_LIMIT
//  PRESCALE    4        tick period in clk cycles (used only with COUNT_SEQ_PRESCALE_EN)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      high only in IDLE; a command is accepted when cmd_valid && cmd_ready
//  cmd_dir    in   1      1 = up, 0 = down; sampled on accept
//  cmd_steps  in   WIDTH  step count; sampled on accept
//  abort      in   1      stop the current command
//  count_in   in   WIDTH  registered count from the counter
//  inc        out  1      counter step enable; one-cycle pulse per step
//  uphdl      out  1      counter direction; equals the latched dir while busy, 0 in IDLE
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse when a command completes or stops
//  limit_hit  out  1      set when a command stops at a limit; cleared on the next accept
// BEHAVIOUR
//  Reset (async): state=IDLE, cmd_ready=1, inc=0, uphdl=0, busy=0, done=0, limit_hit=0,
//   remaining=0. Reset mid-command drops it immediately; no further inc pulses.
//  FSM states: IDLE, CHECK, PULSE, SETTLE, DONE.
//   All outputs are decoded from registered state and flags, so they are glitch-free.
//  IDLE:   on accept, latch dir and remaining=cmd_steps, clear limit_hit.
//          If cmd_steps==0, go to DONE; otherwise go to CHECK.
//  CHECK:  wait for tick. On tick:
//          - (dir==1 && count_in==UP_LIMIT) or (dir==0 && count_in==DOWN_LIMIT):
//            set limit_hit, go to DONE;
//          - otherwise go to PULSE.
//  PULSE:  inc=1 for this single cycle; remaining <= remaining-1; go to SETTLE.
//  SETTLE: one cycle so count_in reflects the step. If remaining==0, go to DONE;
//          otherwise go to CHECK.
//  DONE:   done=1 for one cycle; go to IDLE. cmd_ready returns the cycle after DONE.
//  abort:  in CHECK or SETTLE, go to DONE next cycle; limit_hit unchanged.
//          In PULSE, the pulse already in flight completes, then the FSM goes to DONE
//          instead of SETTLE. In IDLE or DONE, abort is ignored.
//          abort and the limit in the same CHECK cycle: abort wins (limit_hit not set).
//  Throughput: 3 cycles per step without prescale (CHECK, PULSE, SETTLE).
//  Latency: accept to first inc = 2 cycles.
//  remaining is WIDTH bits and never underflows; PULSE is unreachable while remaining==0.
//  cmd_valid while busy is held off (cmd_ready=0); the command is not lost.
// CONFIGURATION
//  COUNT_SEQ_PRESCALE_EN defined: tick = 1 every PRESCALE clk cycles.
//   The free-running divider restarts on accept, so the first tick comes PRESCALE cycles
//   after the accept. Minimum step period = max(3, PRESCALE+2) cycles.
//  COUNT_SEQ_PRESCALE_EN undefined: tick is tied to 1 and there is no divider logic.
// STRUCTURE
//  Shared package count_seq_pkg: state encoding localparams
//   (IDLE=3'd0, CHECK=3'd1, PULSE=3'd2, SETTLE=3'd3, DONE=3'd4), and default UP/DOWN limits.
//  One sub-module: seq_tick_gen, the prescale divider (PRESCALE, clear input, tick output).
//   It is instantiated only under COUNT_SEQ_PRESCALE_EN.
//  The counter itself is instantiated at the top level, not inside this block.
// TESTING
//  Bench connects this block to the up/down counter, with the counter's count fed back to count_in.
//  1. count=0, cmd up, steps=5 -> exactly 5 inc pulses with uphdl=1, count=5, one done pulse,
//     limit_hit=0; first inc 2 cycles after accept.
//  2. count=0, cmd down, steps=3 -> 0 inc pulses, limit_hit=1, done 2 cycles after accept,
//     count stays 0.
//  3. UP_LIMIT=10, count=8, cmd up, steps=5 -> 2 pulses, count=10, limit_hit=1;
//     next accepted command clears limit_hit.
//  4. cmd steps=0 -> done 1 cycle after accept, no inc; cmd_valid held during busy is
//     accepted on return to IDLE.
//  5. Abort during SETTLE of step 2 of 6 -> count moved by exactly 2, done next cycle.
//     Reset asserted during PULSE -> inc=0 and busy=0 immediately.
//  6. COUNT_SEQ_PRESCALE_EN, PRESCALE=4, steps=3 -> inc pulses spaced 6 cycles apart,
//     count moved by 3.

Source files
------------

// File: rtl/count_seq_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_pkg
// Shared definitions for the count_sequencer block: FSM state encoding,
// command direction values and the default count limits.
// ---------------------------------------------------------------------------
package count_seq_pkg;

  // FSM state encoding (3-bit constants kept for compatibility with older users)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_PULSE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Default count limits: the full 16-bit range of the counter
  localparam logic [15:0] DEFAULT_UP_LIMIT   = 16'hFFFF;
  localparam logic [15:0] DEFAULT_DOWN_LIMIT = 16'h0000;

  // Command direction, matching the counter's uphdl encoding
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : count_seq_pkg

// File: rtl/seq_tick_gen.sv
// ---------------------------------------------------------------------------
// seq_tick_gen
// Prescale divider for count_sequencer. o_tick is high for one cycle out of
// every PRESCALE cycles; i_clear restarts the count so the next tick comes
// PRESCALE cycles after the clear is released.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  asynchronous active-high reset
//   i_clear  in  restart the divider
//   o_tick   out tick strobe
// ---------------------------------------------------------------------------
module seq_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  // At least one counter bit, so PRESCALE=1 still builds (tick always high)
  localparam int              CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule : seq_tick_gen

// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
// Command-driven controller for a 16-bit up/down event counter. A command
// "move N steps up/down" is accepted over cmd_valid/cmd_ready; one inc pulse
// is issued per step with uphdl at the commanded direction. The registered
// count is read back on count_in and stepping stops at UP_LIMIT/DOWN_LIMIT so
// the counter never wraps.
// Optional build macro: COUNT_SEQ_PRESCALE_EN -- when defined, steps are paced
// by a PRESCALE-cycle divider (seq_tick_gen); otherwise every cycle is a tick.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  high only in IDLE
//   cmd_dir    in   1 = up, 0 = down (sampled on accept)
//   cmd_steps  in   step count (sampled on accept)
//   abort      in   stop the current command
//   count_in   in   registered count from the counter
//   inc        out  one-cycle step enable per step
//   uphdl      out  latched direction while busy, 0 in IDLE
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a command completes or stops
//   limit_hit  out  command stopped at a limit; cleared on next accept
// ---------------------------------------------------------------------------
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] UP_LIMIT   = WIDTH'(DEFAULT_UP_LIMIT),
  parameter logic [WIDTH-1:0] DOWN_LIMIT = WIDTH'(DEFAULT_DOWN_LIMIT),
  parameter int               PRESCALE   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_steps,
  input  logic             abort,
  input  logic [WIDTH-1:0] count_in,
  output logic             inc,
  output logic             uphdl,
  output logic             busy,
  output logic             done,
  output logic             limit_hit
);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  dir_e             r_dir;
  logic [WIDTH-1:0] r_remaining;
  logic             r_limit_hit;

  logic             w_accept;
  logic             w_tick;
  logic             w_at_limit;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  assign w_at_limit = (r_dir == DIR_UP) ? (count_in == UP_LIMIT)
                                        : (count_in == DOWN_LIMIT);

`ifdef COUNT_SEQ_PRESCALE_EN
  // The divider only runs while waiting in CHECK. Holding it clear in every
  // other state restarts it on accept and again after each SETTLE, so each
  // step waits a full PRESCALE cycles: step period = PRESCALE + 2.
  logic w_tick_clear;
  assign w_tick_clear = (r_state != ST_CHECK);

  seq_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_tick_clear),
    .o_tick  (w_tick)
  );
`else
  // No divider: every CHECK cycle is a tick. PRESCALE is referenced only so
  // it remains a live parameter of this build; the result is always 1.
  assign w_tick = 1'b1 | (PRESCALE == 0);
`endif

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = (cmd_steps == '0) ? ST_DONE : ST_CHECK;
        end
      end
      ST_CHECK: begin
        // abort takes priority over both the tick and the limit test
        if (abort) begin
          w_state_next = ST_DONE;
        end else if (w_tick) begin
          w_state_next = w_at_limit ? ST_DONE : ST_PULSE;
        end
      end
      ST_PULSE: begin
        // The pulse in flight always completes; abort only skips SETTLE
        w_state_next = abort ? ST_DONE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort || (r_remaining == '0)) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_CHECK;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and command registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_DOWN;
      r_remaining <= '0;
      r_limit_hit <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dir       <= dir_e'(cmd_dir);
            r_remaining <= cmd_steps;
            r_limit_hit <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (!abort && w_tick && w_at_limit) begin
            r_limit_hit <= 1'b1;
          end
        end
        ST_PULSE: begin
          // PULSE is only entered with r_remaining >= 1, so no underflow
          r_remaining <= r_remaining - WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode registered state only
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign inc       = (r_state == ST_PULSE);
  assign done      = (r_state == ST_DONE);
  assign uphdl     = (r_dir == DIR_UP) && (r_state != ST_IDLE);
  assign limit_hit = r_limit_hit;

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
// Connects count_sequencer to a behavioural up/down counter whose count is
// fed back on count_in. The counter can be preloaded from the bench so each
// command starts from a chosen count. Limits: UP_LIMIT=10, DOWN_LIMIT=0.
// Honours COUNT_SEQ_PRESCALE_EN (PRESCALE=4) in the expected step timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_count_sequencer;

  localparam int          W        = 16;
  localparam logic [15:0] UP_LIM   = 16'd10;
  localparam logic [15:0] DOWN_LIM = 16'd0;
  localparam int          PRESC    = 4;
`ifdef COUNT_SEQ_PRESCALE_EN
  localparam int          T        = PRESC;  // cycles spent in CHECK per step
`else
  localparam int          T        = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [W-1:0]  cmd_steps = '0;
  logic          abort = 1'b0;
  logic [W-1:0]  count;
  logic          inc, uphdl, busy, done, limit_hit;

  logic          ld_en = 1'b0;
  logic [W-1:0]  ld_val = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  count_sequencer #(
    .WIDTH      (W),
    .UP_LIMIT   (UP_LIM),
    .DOWN_LIMIT (DOWN_LIM),
    .PRESCALE   (PRESC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .count_in  (count),
    .inc       (inc),
    .uphdl     (uphdl),
    .busy      (busy),
    .done      (done),
    .limit_hit (limit_hit)
  );

  // Behavioural up/down counter with a bench preload
  always @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (ld_en) count <= ld_val;
    else if (inc)   count <= uphdl ? count + 16'd1 : count - 16'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference: pulses issued = steps clipped to the room left before the limit;
  // each step takes T+2 cycles; a limit stop adds one more CHECK wait of T.
  // Cycle indices count from the accept edge (0 = first cycle after accept).
  task automatic model(input int start, input int d, input int n,
                       output int p, output int lim, output int dj, output int cnt);
    int room;
    room = d ? (int'(UP_LIM) - start) : (start - int'(DOWN_LIM));
    p    = (n < room) ? n : room;
    lim  = (p < n) ? 1 : 0;
    if (n == 0)   dj = 0;
    else if (lim) dj = (T + 2) * p + T;
    else          dj = (T + 2) * n;
    cnt  = d ? start + p : start - p;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Run one command; ab_at is the cycle index during which abort is held (-1: none)
  task automatic run_cmd(input string nm, input int start, input int d, input int n,
                         input int ab_at, input int exp_p, input int exp_dj,
                         input int exp_lim, input int exp_cnt);
    int pulses, bad_pos, bad_dir, dj;
    wait_idle();
    ld_en = 1'b1; ld_val = W'(start);
    @(posedge clk); #1;
    ld_en = 1'b0;
    cmd_valid = 1'b1; cmd_dir = d[0]; cmd_steps = W'(n);
    @(posedge clk); #1;
    // Scramble command inputs: the DUT must hold its latched copy
    cmd_valid = 1'b0; cmd_dir = ~d[0]; cmd_steps = W'($urandom_range(65535, 0));
    chk({nm, " busy_after_accept"}, int'(busy), 1);
    chk({nm, " limit_clr_on_accept"}, int'(limit_hit), 0);
    pulses = 0; bad_pos = 0; bad_dir = 0; dj = -1;
    for (int j = 0; j < 500; j++) begin
      if (inc) begin
        if (j != T + (T + 2) * pulses) bad_pos++;
        if (uphdl != d[0]) bad_dir++;
        pulses++;
      end
      if (done) begin
        dj = j;
        break;
      end
      abort = (j == ab_at);
      @(posedge clk); #1;
      abort = 1'b0;
    end
    chk({nm, " pulses"}, pulses, exp_p);
    chk({nm, " pulse_timing"}, bad_pos, 0);
    chk({nm, " uphdl_during_inc"}, bad_dir, 0);
    chk({nm, " done_cycle"}, dj, exp_dj);
    chk({nm, " limit_hit"}, int'(limit_hit), exp_lim);
    chk({nm, " count"}, int'(count), exp_cnt);
    @(posedge clk); #1;
    chk({nm, " idle_after_done"}, {27'd0, cmd_ready, busy, done, inc, uphdl}, 32'h10);
    $display("cmd %s start=%0d dir=%0d steps=%0d abort_at=%0d -> pulses=%0d done@%0d limit=%0d count=%0d",
             nm, start, d, n, ab_at, pulses, dj, limit_hit, count);
  endtask

  typedef struct {
    int start;
    int dir;
    int steps;
    int exp_p;
    int exp_lim;
    int exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int p, lim, dj, cnt, s, d, n, k;

    vecs[0] = '{0, 1, 5, 5, 0, 5};    // plain up move
    vecs[1] = '{0, 0, 3, 0, 1, 0};    // down at DOWN_LIMIT: no pulse
    vecs[2] = '{8, 1, 5, 2, 1, 10};   // up, clipped at UP_LIMIT
    vecs[3] = '{10, 0, 4, 4, 0, 6};   // accept clears previous limit_hit
    vecs[4] = '{3, 1, 0, 0, 0, 3};    // zero steps
    vecs[5] = '{10, 1, 1, 0, 1, 10};  // up at UP_LIMIT
    vecs[6] = '{1, 0, 1, 1, 0, 0};    // reach DOWN_LIMIT exactly, no limit stop
    vecs[7] = '{2, 0, 5, 2, 1, 0};    // down, clipped at DOWN_LIMIT
    vecs[8] = '{9, 1, 1, 1, 0, 10};   // reach UP_LIMIT exactly, no limit stop
    vecs[9] = '{0, 1, 3, 3, 0, 3};    // three steps (prescale spacing)

    // Reset state
    #2 reset = 1'b1;
    #3;
    chk("reset_outputs", {26'd0, cmd_ready, inc, uphdl, busy, done, limit_hit}, 32'h20);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven commands
    for (int i = 0; i < 10; i++) begin
      model(vecs[i].start, vecs[i].dir, vecs[i].steps, p, lim, dj, cnt);
      run_cmd($sformatf("vec%0d", i), vecs[i].start, vecs[i].dir, vecs[i].steps, -1,
              vecs[i].exp_p, dj, vecs[i].exp_lim, vecs[i].exp_cnt);
    end

    // Abort in SETTLE of step 2 of 6: two steps taken, done next cycle
    run_cmd("abort_settle", 0, 1, 6, 2 * T + 3, 2, 2 * T + 4, 0, 2);
    // Abort in PULSE: the pulse completes, then straight to DONE
    run_cmd("abort_pulse", 5, 0, 4, T, 1, T + 1, 0, 4);
    // Abort and limit together in CHECK: abort wins, limit_hit stays clear
    run_cmd("abort_vs_limit", 10, 1, 3, 0, 0, 1, 0, 10);

    // cmd_valid held while busy is accepted on return to IDLE
    wait_idle();
    ld_en = 1'b1; ld_val = '0;
    @(posedge clk); #1;
    ld_en = 1'b0;
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd2;
    @(posedge clk); #1;
    cmd_steps = 16'd1;  // second command, held during the first
    k = 0;
    while (!done && k < 200) begin @(posedge clk); #1; k++; end
    chk("hold first_done", int'(done), 1);
    @(posedge clk); #1;
    chk("hold ready_after_done", int'(cmd_ready), 1);
    @(posedge clk); #1;
    chk("hold accepted", int'(busy), 1);
    cmd_valid = 1'b0;
    k = 0;
    while (!done && k < 200) begin @(posedge clk); #1; k++; end
    chk("hold second_done", int'(done), 1);
    chk("hold count", int'(count), 3);
    $display("cmd hold: two commands back to back -> count=%0d", count);

    // Reset during PULSE drops the command at once
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (!inc && k < 50) begin @(posedge clk); #1; k++; end
    chk("rst_pulse reached", int'(inc), 1);
    reset = 1'b1;
    #1;
    chk("rst_pulse outputs", {27'd0, inc, busy, cmd_ready, uphdl, done}, 32'h4);
    @(negedge clk); reset = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (inc || busy) k++;
    end
    chk("rst_pulse quiet_after", k, 0);
    $display("cmd reset_in_pulse: outputs cleared, count=%0d", count);

    // Randomized commands against the reference model
    for (int i = 0; i < 25; i++) begin
      s = $urandom_range(10, 0);
      d = $urandom_range(1, 0);
      n = $urandom_range(12, 0);
      model(s, d, n, p, lim, dj, cnt);
      run_cmd($sformatf("rnd%0d", i), s, d, n, -1, p, dj, lim, cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_count_sequencer
